// File: rtl/motor_pkg.sv
// Shared command codes, mode constant and scheduler state encoding for the motor driver path.
package motor_pkg;

    localparam int unsigned CMD_W  = 6;
    localparam int unsigned DUR_W  = 8;
    localparam int unsigned MODE_W = 2;

    localparam logic [CMD_W-1:0] CMD_FWD   = 6'd1;
    localparam logic [CMD_W-1:0] CMD_REV   = 6'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 6'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 6'd4;
    localparam logic [CMD_W-1:0] CMD_STOP  = 6'd9;
    localparam logic [CMD_W-1:0] CMD_MAX   = 6'd11;

    localparam logic [MODE_W-1:0] MODE_DRIVE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_ESC_STOP,
        ST_ESC_BACK,
        ST_ESC_TURN,
        ST_ESTOP
    } sched_state_e;

    function automatic logic cmd_is_valid(input logic [CMD_W-1:0] code);
        return (code != '0) && (code <= CMD_MAX);
    endfunction

endpackage

// File: rtl/motor_tick.sv
// Duration-unit prescaler: counts 0..TICK_CYC-1 and flags the wrap cycle; clr restarts the count.
module motor_tick #(
    parameter int unsigned TICK_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(TICK_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/motor_cmd_sched.sv
// Arbitrates emergency stop, obstacle escape and timed manual commands into the motor driver command.
module motor_cmd_sched
    import motor_pkg::*;
#(
    parameter int unsigned TICK_CYC   = 500000,
    parameter int unsigned ESC_STOP_T = 10,
    parameter int unsigned ESC_BACK_T = 30,
    parameter int unsigned ESC_TURN_T = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              obs,
    input  logic              man_valid,
    input  logic [CMD_W-1:0]  man_cmd,
    input  logic [DUR_W-1:0]  man_dur,
    output logic              man_ready,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [MODE_W-1:0] mode_out,
    output logic              busy,
    output logic              esc_done,
    output logic              cmd_err
);

    sched_state_e     state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             timed_q, timed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tick;
    logic             accept_ok;
    logic             phase_end;
    logic             tick_clr;

    assign man_ready = ((state_q == ST_IDLE) || (state_q == ST_MANUAL)) && !estop && !obs && !rst;
    assign accept_ok = man_valid && man_ready && cmd_is_valid(man_cmd);
    assign phase_end = tick && (cnt_q == DUR_W'(1));
    // Any state entry or re-accept restarts the prescaler so every phase is exactly N units.
    assign tick_clr  = accept_ok || (state_d != state_q);

    motor_tick #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        timed_d = timed_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - DUR_W'(1);
        end

        if (estop) begin
            state_d = ST_ESTOP;
            cmd_d   = CMD_STOP;
            cnt_d   = '0;
            timed_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_MANUAL: begin
                    if (obs) begin
                        state_d = ST_ESC_STOP;
                        cmd_d   = CMD_STOP;
                        cnt_d   = DUR_W'(ESC_STOP_T);
                        timed_d = 1'b0;
                    end else if (accept_ok) begin
                        state_d = ST_MANUAL;
                        cmd_d   = man_cmd;
                        cnt_d   = man_dur;
                        timed_d = (man_dur != '0);
                    end else begin
                        err_d = man_valid;
                        if ((state_q == ST_MANUAL) && timed_q && phase_end) begin
                            state_d = ST_IDLE;
                            cmd_d   = CMD_STOP;
                            cnt_d   = '0;
                            timed_d = 1'b0;
                        end
                    end
                end
                ST_ESC_STOP: begin
                    if (phase_end) begin
                        state_d = ST_ESC_BACK;
                        cmd_d   = CMD_REV;
                        cnt_d   = DUR_W'(ESC_BACK_T);
                    end
                end
                ST_ESC_BACK: begin
                    if (phase_end) begin
                        state_d = ST_ESC_TURN;
                        cmd_d   = CMD_RIGHT;
                        cnt_d   = DUR_W'(ESC_TURN_T);
                    end
                end
                ST_ESC_TURN: begin
                    if (phase_end) begin
                        state_d = ST_IDLE;
                        cmd_d   = CMD_STOP;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                ST_ESTOP: begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_STOP;
                    cnt_d   = '0;
                    timed_d = 1'b0;
                end
            endcase
        end

        busy_d = ((state_d == ST_MANUAL) && timed_d) || (state_d == ST_ESC_STOP) ||
                 (state_d == ST_ESC_BACK) || (state_d == ST_ESC_TURN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_STOP;
            cnt_q   <= '0;
            timed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            timed_q <= timed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_out  = cmd_q;
    assign mode_out = MODE_DRIVE;
    assign busy     = busy_q;
    assign esc_done = done_q;
    assign cmd_err  = err_q;

endmodule
